// File: rtl/ub_pkg.sv
// Shared sizes, requester IDs and read-FSM state type for the unified-buffer access controller.
package ub_pkg;

    localparam int UB_DEPTH = 256;
    localparam int UB_WIDTH = 128;
    localparam int UB_AW    = $clog2(UB_DEPTH);

    // Owner tag carried with each read beat
    localparam logic REQ_H = 1'b0;
    localparam logic REQ_A = 1'b1;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

endpackage

// File: rtl/ub_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the host requester, bit 1 the array requester.
// The priority pointer moves to the losing side only after a contested grant, so a lone
// requester never disturbs the fairness order.
module ub_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 = host has priority on the next contested cycle, 1 = array has priority
    logic ptr_reg;

    // Grant the lone requester, or the pointer's favourite when both ask
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Hand priority to the loser once a contested grant is actually consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            ptr_reg <= ~ptr_reg;
        end
    end

endmodule

// File: rtl/ub_access_ctrl.sv
// Unified-buffer access controller: shares the simple-dual-port BRAM between the host and
// the array. Write port: single-beat round-robin, zero latency. Read port: round-robin
// burst requests, one address per cycle, data returned one cycle after the enable.
// Optional macro UB_RAW_BYPASS_EN: a read colliding with a same-cycle write to the same
// address returns the new write data instead of the BRAM's read-first old data.
module ub_access_ctrl
    import ub_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    // write requesters
    input  logic                h_wr_valid,
    output logic                h_wr_ready,
    input  logic [UB_AW-1:0]    h_wr_addr,
    input  logic [UB_WIDTH-1:0] h_wr_data,
    input  logic                a_wr_valid,
    output logic                a_wr_ready,
    input  logic [UB_AW-1:0]    a_wr_addr,
    input  logic [UB_WIDTH-1:0] a_wr_data,
    // read-burst requesters
    input  logic                h_rd_req_valid,
    output logic                h_rd_req_ready,
    input  logic [UB_AW-1:0]    h_rd_req_addr,
    input  logic [UB_AW-1:0]    h_rd_req_len,
    input  logic                a_rd_req_valid,
    output logic                a_rd_req_ready,
    input  logic [UB_AW-1:0]    a_rd_req_addr,
    input  logic [UB_AW-1:0]    a_rd_req_len,
    // read return
    output logic                rd_data_valid,
    output logic [UB_WIDTH-1:0] rd_data,
    output logic                rd_data_id,
    output logic                rd_data_last,
    output logic                rd_busy,
    // BRAM
    output logic                ub_wea,
    output logic [UB_AW-1:0]    ub_addra,
    output logic [UB_WIDTH-1:0] ub_dina,
    output logic                ub_enb,
    output logic [UB_AW-1:0]    ub_addrb,
    input  logic [UB_WIDTH-1:0] ub_doutb
);

    logic [1:0] wr_req;
    logic [1:0] wr_grant;
    logic [1:0] rd_req;
    logic [1:0] rd_grant;
    logic       rd_idle;

    rd_state_t          state_reg;
    logic               enb_reg;
    logic [UB_AW-1:0]   addrb_reg;
    logic [UB_AW-1:0]   cnt_reg;
    logic               id_reg;
    logic               last_beat;
    logic               rd_valid_reg;
    logic               rd_id_reg;
    logic               rd_last_reg;

    // ---------------- write port ----------------
    assign wr_req = {a_wr_valid, h_wr_valid} & {2{~rst}};

    ub_rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req),
        .advance (|wr_req),
        .grant   (wr_grant)
    );

    assign h_wr_ready = wr_grant[0];
    assign a_wr_ready = wr_grant[1];
    assign ub_wea     = |wr_req;
    assign ub_addra   = wr_grant[1] ? a_wr_addr : h_wr_addr;
    assign ub_dina    = wr_grant[1] ? a_wr_data : h_wr_data;

    // ---------------- read request port ----------------
    assign rd_idle = (state_reg == RD_IDLE);
    assign rd_req  = {a_rd_req_valid, h_rd_req_valid} & {2{rd_idle & ~rst}};

    ub_rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_req),
        .advance (rd_idle),
        .grant   (rd_grant)
    );

    assign h_rd_req_ready = rd_grant[0];
    assign a_rd_req_ready = rd_grant[1];

    // Burst sequencer: latch the winning request, then walk addresses until the count runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RD_IDLE;
            enb_reg   <= 1'b0;
            addrb_reg <= '0;
            cnt_reg   <= '0;
            id_reg    <= REQ_H;
        end else begin
            case (state_reg)
                RD_IDLE: begin
                    if (|rd_grant) begin
                        state_reg <= RD_BURST;
                        enb_reg   <= 1'b1;
                        addrb_reg <= rd_grant[1] ? a_rd_req_addr : h_rd_req_addr;
                        cnt_reg   <= rd_grant[1] ? a_rd_req_len  : h_rd_req_len;
                        id_reg    <= rd_grant[1] ? REQ_A : REQ_H;
                    end
                end
                RD_BURST: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RD_IDLE;
                        enb_reg   <= 1'b0;
                    end else begin
                        addrb_reg <= addrb_reg + UB_AW'(1);
                        cnt_reg   <= cnt_reg - UB_AW'(1);
                    end
                end
                default: begin
                    state_reg <= RD_IDLE;
                    enb_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ub_enb    = enb_reg;
    assign ub_addrb  = addrb_reg;
    assign rd_busy   = (state_reg == RD_BURST);
    assign last_beat = enb_reg && (cnt_reg == '0);

    // Beat side-band follows the BRAM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_id_reg    <= 1'b0;
            rd_last_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= enb_reg;
            rd_id_reg    <= id_reg;
            rd_last_reg  <= last_beat;
        end
    end

    assign rd_data_valid = rd_valid_reg;
    assign rd_data_id    = rd_id_reg;
    assign rd_data_last  = rd_last_reg;

`ifdef UB_RAW_BYPASS_EN
    logic                raw_hit_reg;
    logic [UB_WIDTH-1:0] raw_data_reg;

    // Capture same-address write data so the colliding read sees the new value
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_hit_reg  <= 1'b0;
            raw_data_reg <= '0;
        end else begin
            raw_hit_reg  <= ub_wea && ub_enb && (ub_addra == ub_addrb);
            raw_data_reg <= ub_dina;
        end
    end

    assign rd_data = raw_hit_reg ? raw_data_reg : ub_doutb;
`else
    assign rd_data = ub_doutb;
`endif

endmodule
